// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
//   Shared types and default constants for the button event decoder.
//   - state_t        : decoder FSM states
//   - DEF_LONG_CYCLES: default cycles in PRESSED before a hold counts as long
//   - DEF_REPEAT_CYCLES: default auto-repeat period while long-held
//   - DEF_CNT_W      : default duration counter width
// -----------------------------------------------------------------------------
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    LONGHELD = 2'd2
  } state_t;

  localparam int DEF_LONG_CYCLES   = 16;
  localparam int DEF_REPEAT_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//   Turns a debounced button level into one-cycle event pulses (press, short,
//   long, auto-repeat, release) plus a held level, so downstream control logic
//   never has to time button durations itself.
//
// Parameters
//   LONG_CYCLES   : cycles in PRESSED before a hold counts as long (2..2^CNT_W)
//   REPEAT_CYCLES : OUTREPEAT period while long-held (1..2^CNT_W)
//   CNT_W         : duration counter width
//
// Ports
//   IPTCLK     in  clock, rising edge
//   IPTRSTN    in  asynchronous active-low reset
//   IPTBTN     in  debounced button level, 1 = pressed
//   OUTPRESS   out 1-cycle pulse on press detection
//   OUTSHORT   out 1-cycle pulse on release before the long threshold
//   OUTLONG    out 1-cycle pulse when the long threshold is reached
//   OUTREPEAT  out 1-cycle pulse every REPEAT_CYCLES while long-held
//   OUTRELEASE out 1-cycle pulse on every release
//   OUTHELD    out level, 1 while in PRESSED or LONGHELD
// -----------------------------------------------------------------------------
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic IPTCLK,
  input  logic IPTRSTN,
  input  logic IPTBTN,
  output logic OUTPRESS,
  output logic OUTSHORT,
  output logic OUTLONG,
  output logic OUTREPEAT,
  output logic OUTRELEASE,
  output logic OUTHELD
);

  // Terminal counts; the counter restarts at 0 on every state entry, so the
  // threshold is hit after exactly LONG_CYCLES / REPEAT_CYCLES cycles.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             btn_q_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic press_reg,   press_next;
  logic short_reg,   short_next;
  logic long_reg,    long_next;
  logic repeat_reg,  repeat_next;
  logic release_reg, release_next;
  logic held_reg,    held_next;

  // ---------------------------------------------------------------------------
  // State, counter, input stage and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge IPTCLK or negedge IPTRSTN) begin
    if (!IPTRSTN) begin
      btn_q_reg   <= 1'b0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      short_reg   <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
      release_reg <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      btn_q_reg   <= IPTBTN;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      short_reg   <= short_next;
      long_reg    <= long_next;
      repeat_reg  <= repeat_next;
      release_reg <= release_next;
      held_reg    <= held_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, counter and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    release_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (btn_q_reg) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end
      end

      PRESSED: begin
        // Release is checked first so it wins over a coincident threshold.
        if (!btn_q_reg) begin
          state_next   = IDLE;
          cnt_next     = '0;
          short_next   = 1'b1;
          release_next = 1'b1;
        end else if (cnt_reg == LONG_LAST) begin
          state_next = LONGHELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      LONGHELD: begin
        if (!btn_q_reg) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else if (cnt_reg == REPEAT_LAST) begin
          cnt_next    = '0;
          repeat_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Held follows the state being entered so it moves together with the
    // press/release pulses.
    held_next = (state_next != IDLE);
  end

  assign OUTPRESS   = press_reg;
  assign OUTSHORT   = short_reg;
  assign OUTLONG    = long_reg;
  assign OUTREPEAT  = repeat_reg;
  assign OUTRELEASE = release_reg;
  assign OUTHELD    = held_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//   Directed bench for button_event_decoder with default parameters.
//   Edge numbering: edge 0 is the first rising edge at which IPTBTN is sampled
//   high; "after edge e" means sampled 1 time unit past that edge.
//   Output vector order: {press, short, long, repeat, release, held}.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int REP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic o_press, o_short, o_long, o_repeat, o_release, o_held;

  int total = 0;
  int bad = 0;

  button_event_decoder dut (
    .IPTCLK    (clk),
    .IPTRSTN   (rst_n),
    .IPTBTN    (btn),
    .OUTPRESS  (o_press),
    .OUTSHORT  (o_short),
    .OUTLONG   (o_long),
    .OUTREPEAT (o_repeat),
    .OUTRELEASE(o_release),
    .OUTHELD   (o_held)
  );

  always #5 clk = ~clk;

  // One press scenario: IPTBTN high at edges 0..n-1, then low.
  typedef struct {
    int n;        // consecutive high samples
    int long_e;   // edge after which OUTLONG pulses, -1 = never
    int nrep;     // number of OUTREPEAT pulses
    int rel_e;    // edge after which OUTRELEASE pulses
    bit shrt;     // OUTSHORT together with OUTRELEASE
  } vec_t;

  vec_t vecs[7];

  function automatic logic [5:0] outs();
    return {o_press, o_short, o_long, o_repeat, o_release, o_held};
  endfunction

  task automatic check(input string name, input int e, input logic [5:0] act,
                       input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, e, act, exp);
    end
  endtask

  initial begin
    logic [5:0] exp;
    int bad_before;

    // Hand-computed expectations for LONG=16, REPEAT=4.
    vecs[0] = '{n: 6,  long_e: -1, nrep: 0, rel_e: 7,  shrt: 1'b1};
    vecs[1] = '{n: 1,  long_e: -1, nrep: 0, rel_e: 2,  shrt: 1'b1};
    vecs[2] = '{n: 16, long_e: -1, nrep: 0, rel_e: 17, shrt: 1'b1};
    vecs[3] = '{n: 17, long_e: 17, nrep: 0, rel_e: 18, shrt: 1'b0};
    vecs[4] = '{n: 20, long_e: 17, nrep: 0, rel_e: 21, shrt: 1'b0};
    vecs[5] = '{n: 21, long_e: 17, nrep: 1, rel_e: 22, shrt: 1'b0};
    vecs[6] = '{n: 30, long_e: 17, nrep: 3, rel_e: 31, shrt: 1'b0};

    // Reset with button low, then idle.
    repeat (3) @(posedge clk);
    #1 check("reset_state", -1, outs(), 6'b000000);
    @(negedge clk) rst_n = 1'b1;
    bad_before = bad;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 check("idle_quiet", i, outs(), 6'b000000);
    end
    $display("txn idle: 20 cycles errors=%0d", bad - bad_before);

    // Table-driven press scenarios.
    for (int v = 0; v < 7; v++) begin
      bad_before = bad;
      for (int e = 0; e <= vecs[v].rel_e + 3; e++) begin
        btn = (e < vecs[v].n);
        @(posedge clk);
        #1;
        exp[5] = (e == 1);
        exp[4] = vecs[v].shrt && (e == vecs[v].rel_e);
        exp[3] = (e == vecs[v].long_e);
        exp[2] = (vecs[v].long_e >= 0) && (e > vecs[v].long_e) &&
                 ((e - vecs[v].long_e) % REP == 0) &&
                 (e <= vecs[v].long_e + vecs[v].nrep * REP);
        exp[1] = (e == vecs[v].rel_e);
        exp[0] = (e >= 1) && (e < vecs[v].rel_e);
        check($sformatf("vec%0d_n%0d", v, vecs[v].n), e, outs(), exp);
      end
      $display("txn vec%0d: n=%0d long=%0d reps=%0d rel=%0d errors=%0d",
               v, vecs[v].n, vecs[v].long_e, vecs[v].nrep, vecs[v].rel_e,
               bad - bad_before);
    end

    // Back-to-back: high 0..2, low at 3, high 4..6. Second press is seen the
    // cycle after the first release.
    bad_before = bad;
    for (int e = 0; e < 12; e++) begin
      btn = ((e <= 2) || (e >= 4 && e <= 6));
      @(posedge clk);
      #1;
      exp[5] = (e == 1) || (e == 5);
      exp[4] = (e == 4) || (e == 8);
      exp[3] = 1'b0;
      exp[2] = 1'b0;
      exp[1] = (e == 4) || (e == 8);
      exp[0] = (e >= 1 && e <= 3) || (e >= 5 && e <= 7);
      check("back_to_back", e, outs(), exp);
    end
    $display("txn back_to_back: errors=%0d", bad - bad_before);

    // Reset in the middle of LONGHELD, then release reset with button held.
    bad_before = bad;
    for (int e = 0; e <= 19; e++) begin
      btn = 1'b1;
      @(posedge clk);
      #1;
      if (e == 17) check("mh_long", e, outs(), 6'b001001);
      if (e == 19) check("mh_held", e, outs(), 6'b000001);
    end
    #2 rst_n = 1'b0;
    #1 check("mh_async_rst", -1, outs(), 6'b000000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("mh_in_rst", i, outs(), 6'b000000);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("mh_post_e0", 0, outs(), 6'b000000);
    @(posedge clk);
    #1 check("mh_post_press", 1, outs(), 6'b100001);
    btn = 1'b0;
    @(posedge clk);
    #1 check("mh_post_hold", 2, outs(), 6'b000001);
    @(posedge clk);
    #1 check("mh_post_rel", 3, outs(), 6'b010010);
    @(posedge clk);
    #1 check("mh_post_idle", 4, outs(), 6'b000000);
    $display("txn reset_mid_hold: errors=%0d", bad - bad_before);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, debounced button level produced by the button debouncer and turns it into one-cycle event pulses: press, short-press, long-press, auto-repeat and release, plus a held level. It sits between the debouncer output and the control FSMs that act on user input, so downstream logic never has to time button durations itself.

## Interface
- LONG_CYCLES, 16: cycles in PRESSED before a hold counts as long; legal range 2..2^CNT_W
- REPEAT_CYCLES, 4: period of OUTREPEAT pulses while long-held; legal range 1..2^CNT_W
- CNT_W, 8: duration counter width
- IPTCLK  in  1  clock, all state updates on rising edge
- IPTRSTN  in  1  asynchronous active-low reset
- IPTBTN  in  1  debounced button level, 1 = pressed
- OUTPRESS  out  1  1-cycle pulse on press detection
- OUTSHORT  out  1  1-cycle pulse on release before long threshold
- OUTLONG  out  1  1-cycle pulse when long threshold reached
- OUTREPEAT  out  1  1-cycle pulse every REPEAT_CYCLES while long-held
- OUTRELEASE  out  1  1-cycle pulse on every release
- OUTHELD  out  1  level, 1 while state is PRESSED or LONGHELD

## Operation
- Input stage: IPTBTN registered once into btn_q; FSM acts only on btn_q.
- States: IDLE, PRESSED, LONGHELD; cnt is CNT_W bits.
- IDLE: btn_q=1 -> PRESSED, cnt<=0, OUTPRESS=1.
- PRESSED: btn_q=0 -> IDLE, OUTSHORT=1, OUTRELEASE=1; else cnt==LONG_CYCLES-1 -> LONGHELD, cnt<=0, OUTLONG=1; else cnt<=cnt+1.
- LONGHELD: btn_q=0 -> IDLE, OUTRELEASE=1; else cnt==REPEAT_CYCLES-1 -> cnt<=0, OUTREPEAT=1; else cnt<=cnt+1.
- All outputs registered; at most one of OUTPRESS/OUTLONG/OUTREPEAT/OUTRELEASE per cycle; OUTSHORT only together with OUTRELEASE.
- Release wins: btn_q=0 in the cycle cnt hits a threshold -> release handling only, no OUTLONG/OUTREPEAT.
- Counter never wraps: cleared on every threshold hit and every state entry.
- Reset: state IDLE, cnt=0, btn_q=0, every output 0. IPTBTN already high at reset release counts as a new press.
- Reset mid-hold: all state discarded, no OUTRELEASE emitted.

## Timing
- IPTBTN high at edge n -> btn_q=1 after edge n -> OUTPRESS high for the cycle after edge n+1 (2-edge latency); OUTHELD rises with it.
- Press sampled high at N consecutive edges n..n+N-1: N<=LONG_CYCLES -> short; N>=LONG_CYCLES+1 -> OUTLONG after edge n+LONG_CYCLES+1.
- OUTREPEAT after edges n+LONG_CYCLES+1+k*REPEAT_CYCLES, k>=1, while held.
- IPTBTN low at edge m -> OUTRELEASE (and OUTSHORT if applicable) after edge m+1; OUTHELD falls with it.
- Back-to-back: a new press may be detected the cycle after OUTRELEASE (IDLE sees btn_q=1 on next edge).

## Structure
- Package button_event_pkg: state enum (IDLE, PRESSED, LONGHELD), default parameter constants.
- Single module, no sub-module; input register, FSM, counter and output registers inline.

## Test plan
- Reset with IPTBTN=0 -> all outputs 0, OUTHELD 0; release IPTRSTN, idle 20 cycles -> no pulses.
- Defaults, IPTBTN high at edges 0..5 -> OUTPRESS after edge 1, OUTSHORT+OUTRELEASE after edge 7, no OUTLONG.
- Defaults, IPTBTN high at edges 0..15 (N=16) -> short; high at edges 0..16 (N=17) -> OUTLONG after edge 17, no OUTSHORT.
- Defaults, IPTBTN high at edges 0..29 -> OUTLONG after 17, OUTREPEAT after 21, 25, 29; OUTRELEASE after 31; no OUTREPEAT at 33.
- Boundary: release timed so btn_q=0 at edge 17 (N=16) -> OUTRELEASE+OUTSHORT, OUTLONG never asserted; repeat with release at first OUTREPEAT edge -> OUTRELEASE only.
- Assert IPTRSTN=0 mid-LONGHELD -> outputs 0 immediately (asynchronous), no OUTRELEASE; deassert with IPTBTN=1 -> OUTPRESS 2 edges later.
